// File: rtl/accum_zone_engine.sv
// accum_zone_engine: multi-port accumulation store over NUM_BANKS parallel banks.
// A round-robin arbiter admits one write or read per cycle into a two-stage
// read-modify-write pipeline. Same-row back-to-back operations are served from a
// forwarding register because the bank read in S0 cannot see the S1 write.
// Optional build macro: ACCUM_SATURATE_EN (saturating accumulate instead of wrap).

module accum_zone_bank #(
    parameter int ADDR_WIDTH = 9,
    parameter int DATA_WIDTH = 64
) (
    input  logic                  clk,
    input  logic [ADDR_WIDTH-1:0] rd_addr,
    input  logic                  wr_en,
    input  logic [ADDR_WIDTH-1:0] wr_addr,
    input  logic [DATA_WIDTH-1:0] wr_data,
    output logic [DATA_WIDTH-1:0] rd_q
);
    logic [DATA_WIDTH-1:0] mem [2**ADDR_WIDTH];

    // Synchronous write and read; a same-cycle read returns the old word.
    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= wr_data;
        rd_q <= mem[rd_addr];
    end
endmodule

module accum_zone_engine #(
    parameter int NUM_PORTS  = 4,
    parameter int NUM_BANKS  = 4,
    parameter int ADDR_WIDTH = 9,
    parameter int DATA_WIDTH = 64
) (
    input  logic                                     clk,
    input  logic                                     rst,
    input  logic [NUM_PORTS-1:0]                     wr_valid,
    output logic [NUM_PORTS-1:0]                     wr_ready,
    input  logic [NUM_PORTS*ADDR_WIDTH-1:0]          wr_addr,
    input  logic [NUM_PORTS*NUM_BANKS-1:0]           wr_mask,
    input  logic [NUM_PORTS-1:0]                     accum_en,
    input  logic [NUM_PORTS-1:0]                     wvalid,
    output logic [NUM_PORTS-1:0]                     wready,
    input  logic [NUM_PORTS*NUM_BANKS*DATA_WIDTH-1:0] wdata,
    input  logic [NUM_PORTS-1:0]                     rd_valid,
    output logic [NUM_PORTS-1:0]                     rd_ready,
    input  logic [NUM_PORTS*ADDR_WIDTH-1:0]          rd_addr,
    input  logic [NUM_PORTS*NUM_BANKS-1:0]           rd_mask,
    output logic [NUM_PORTS-1:0]                     rvalid,
    output logic [NUM_BANKS*DATA_WIDTH-1:0]          rdata,
    output logic                                     busy
);
    localparam int SLOTS     = 2 * NUM_PORTS;
    localparam int SW        = $clog2(SLOTS);
    localparam int PID_WIDTH = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    localparam int ROW_W     = NUM_BANKS * DATA_WIDTH;

    typedef struct packed {
        logic                                  wr;
        logic [PID_WIDTH-1:0]                  pid;
        logic [ADDR_WIDTH-1:0]                 addr;
        logic [NUM_BANKS-1:0]                  mask;
        logic                                  acc;
        logic [NUM_BANKS-1:0][DATA_WIDTH-1:0]  wdata;
    } op_t;

    logic [SLOTS-1:0] req;
    logic [SW-1:0]    ptr, win;
    logic             found, gnt, win_wr;
    logic [PID_WIDTH-1:0] win_pid;
    int               idx, wp;
    op_t              s0_op, s1_op;
    logic             s1_vld, s1_wr_vld, rd_pulse, addr_match;

    logic [NUM_BANKS-1:0][DATA_WIDTH-1:0] mem_q, old_word, new_word, fwd_word;
    logic [NUM_BANKS-1:0]                 fwd_hit, hit_next, bank_we;

    // Slots 0..N-1 are writes (command and data both present), N..2N-1 reads.
    assign req = {rd_valid, wr_valid & wvalid};

    // Round-robin search starting at ptr; first requesting slot wins.
    always_comb begin
        found = 1'b0;
        win   = '0;
        idx   = 0;
        for (int k = 0; k < SLOTS; k++) begin
            idx = int'(ptr) + k;
            if (idx >= SLOTS) idx = idx - SLOTS;
            if (!found && req[SW'(idx)]) begin
                found = 1'b1;
                win   = SW'(idx);
            end
        end
    end

    assign gnt = found && !rst;

    // Decode the winner and mux its request into the S0 operation.
    always_comb begin
        win_wr        = int'(win) < NUM_PORTS;
        wp            = win_wr ? int'(win) : int'(win) - NUM_PORTS;
        win_pid       = PID_WIDTH'(wp);
        s0_op.wr      = win_wr;
        s0_op.pid     = win_pid;
        s0_op.addr    = win_wr ? wr_addr[wp*ADDR_WIDTH +: ADDR_WIDTH]
                               : rd_addr[wp*ADDR_WIDTH +: ADDR_WIDTH];
        s0_op.mask    = win_wr ? wr_mask[wp*NUM_BANKS +: NUM_BANKS]
                               : rd_mask[wp*NUM_BANKS +: NUM_BANKS];
        s0_op.acc     = win_wr && accum_en[wp];
        s0_op.wdata   = wdata[wp*ROW_W +: ROW_W];
    end

    // One-cycle grant strobes; write command and data are accepted together.
    always_comb begin
        wr_ready = '0;
        rd_ready = '0;
        if (gnt) begin
            if (win_wr) wr_ready[win_pid] = 1'b1;
            else        rd_ready[win_pid] = 1'b1;
        end
    end
    assign wready = wr_ready;

    // Pointer moves just past the winner; holds when nothing is granted.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)      ptr <= '0;
        else if (gnt) ptr <= (int'(win) == SLOTS-1) ? '0 : win + 1'b1;
    end

    // S1 occupancy; reset drops whatever was in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) s1_vld <= 1'b0;
        else     s1_vld <= gnt;
    end

    // S1 payload, only meaningful while s1_vld is set.
    always_ff @(posedge clk) begin
        if (gnt) s1_op <= s0_op;
    end

    assign s1_wr_vld  = s1_vld && s1_op.wr;
    assign rd_pulse   = s1_vld && !s1_op.wr;
    assign addr_match = s0_op.addr == s1_op.addr;

    for (genvar b = 0; b < NUM_BANKS; b++) begin : g_bank
        logic [DATA_WIDTH-1:0] acc_sum;

        accum_zone_bank #(.ADDR_WIDTH(ADDR_WIDTH), .DATA_WIDTH(DATA_WIDTH)) u_bank (
            .clk     (clk),
            .rd_addr (s0_op.addr),
            .wr_en   (bank_we[b]),
            .wr_addr (s1_op.addr),
            .wr_data (new_word[b]),
            .rd_q    (mem_q[b])
        );

        assign old_word[b] = fwd_hit[b] ? fwd_word[b] : mem_q[b];
`ifdef ACCUM_SATURATE_EN
        logic [DATA_WIDTH:0] sum_ext;
        assign sum_ext = {1'b0, old_word[b]} + {1'b0, s1_op.wdata[b]};
        assign acc_sum = sum_ext[DATA_WIDTH] ? '1 : sum_ext[DATA_WIDTH-1:0];
`else
        assign acc_sum = old_word[b] + s1_op.wdata[b];
`endif
        assign new_word[b] = s1_op.acc ? acc_sum : s1_op.wdata[b];
        assign bank_we[b]  = s1_wr_vld && s1_op.mask[b] && !rst;
        assign hit_next[b] = gnt && s1_wr_vld && s1_op.mask[b] && addr_match;
        assign rdata[b*DATA_WIDTH +: DATA_WIDTH] =
            (rd_pulse && s1_op.mask[b]) ? old_word[b] : '0;
    end

    // Hit flags mark banks whose S1 result must replace the stale bank read.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) fwd_hit <= '0;
        else     fwd_hit <= hit_next;
    end

    // Forwarded word is the S1 result of the previous cycle.
    always_ff @(posedge clk) begin
        fwd_word <= new_word;
    end

    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_rv
        assign rvalid[p] = rd_pulse && (s1_op.pid == PID_WIDTH'(p));
    end

    assign busy = (|req) || s1_vld;
endmodule

// File: tb/tb_accum_zone_engine.sv
// Self-checking bench for accum_zone_engine: read results go through a
// scoreboard filled from a reference memory model at grant time.
// Honours ACCUM_SATURATE_EN the same way as the design.

module tb_accum_zone_engine;
    logic          clk, rst;
    logic [3:0]    wr_valid, wr_ready, accum_en, wvalid, wready;
    logic [3:0]    rd_valid, rd_ready, rvalid;
    logic [35:0]   wr_addr, rd_addr;
    logic [15:0]   wr_mask, rd_mask;
    logic [1023:0] wdata;
    logic [255:0]  rdata;
    logic          busy;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct packed {
        logic [1:0]   pid;
        logic [255:0] data;
    } exp_t;
    exp_t sb[$];

    logic [63:0] model [4][512];

    accum_zone_engine dut (
        .clk(clk), .rst(rst),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_addr(wr_addr), .wr_mask(wr_mask),
        .accum_en(accum_en), .wvalid(wvalid), .wready(wready), .wdata(wdata),
        .rd_valid(rd_valid), .rd_ready(rd_ready), .rd_addr(rd_addr), .rd_mask(rd_mask),
        .rvalid(rvalid), .rdata(rdata), .busy(busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic void model_write(input logic [8:0] a, input logic [3:0] m,
                                        input logic acc, input logic [3:0][63:0] d);
        logic [64:0] s;
        for (int b = 0; b < 4; b++) begin
            if (m[b]) begin
                if (acc) begin
                    s = {1'b0, model[b][a]} + {1'b0, d[b]};
`ifdef ACCUM_SATURATE_EN
                    model[b][a] = s[64] ? '1 : s[63:0];
`else
                    model[b][a] = s[63:0];
`endif
                end else begin
                    model[b][a] = d[b];
                end
            end
        end
    endfunction

    function automatic logic [255:0] model_read(input logic [8:0] a, input logic [3:0] m);
        logic [3:0][63:0] r;
        for (int b = 0; b < 4; b++) r[b] = m[b] ? model[b][a] : 64'd0;
        return r;
    endfunction

    // Output monitor: rvalid timing, read data against scoreboard, ready rules.
    initial begin
        logic [3:0] prev_rd_ready, exp_rv;
        exp_t e;
        prev_rd_ready = '0;
        forever begin
            @(negedge clk);
            exp_rv = rst ? 4'b0 : prev_rd_ready;
            if (exp_rv != 0 || rvalid != 0) begin
                n_checks++;
                if (rvalid !== exp_rv) begin
                    n_fail++;
                    $display("FAIL rvalid_timing: got %b want %b at %0t", rvalid, exp_rv, $time);
                end
            end
            if (rvalid != 0 && !rst) begin
                n_checks++;
                if (sb.size() == 0) begin
                    n_fail++;
                    $display("FAIL unexpected_rvalid: got %b with empty scoreboard", rvalid);
                end else begin
                    e = sb.pop_front();
                    if (rvalid !== (4'b0001 << e.pid) || rdata !== e.data) begin
                        n_fail++;
                        $display("FAIL read_data: port got %b want %b data got %h want %h",
                                 rvalid, 4'b0001 << e.pid, rdata, e.data);
                    end
                end
            end
            if ((wr_ready | wready | rd_ready) != 0) begin
                n_checks++;
                if ((wr_ready & ~(wr_valid & wvalid)) != 0 || (rd_ready & ~rd_valid) != 0 ||
                    wready !== wr_ready || $countones({wr_ready, rd_ready}) > 1) begin
                    n_fail++;
                    $display("FAIL ready_rules: wr_ready %b wready %b rd_ready %b", wr_ready, wready, rd_ready);
                end
            end
            prev_rd_ready = rst ? 4'b0 : rd_ready;
        end
    end

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic apply_reset();
        idle(3);
        rst = 1'b1;
        idle(2);
        rst = 1'b0;
    endtask

    task automatic do_write(input int p, input logic [8:0] a, input logic [3:0] m, input logic acc,
                            input logic [3:0][63:0] d, output int waited);
        bit got;
        got = 0;
        waited = 0;
        wr_valid[p] = 1'b1; wvalid[p] = 1'b1; accum_en[p] = acc;
        wr_addr[p*9 +: 9] = a; wr_mask[p*4 +: 4] = m; wdata[p*256 +: 256] = d;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (wr_ready[p] === 1'b1) begin
                got = 1;
                break;
            end
            waited++;
            @(posedge clk); #1;
        end
        n_checks++;
        if (!got || wready[p] !== 1'b1) begin
            n_fail++;
            $display("FAIL write_grant: port %0d got wr_ready %b wready %b want both set", p, wr_ready, wready);
        end
        if (got) model_write(a, m, acc, d);
        @(posedge clk); #1;
        wr_valid[p] = 1'b0; wvalid[p] = 1'b0;
    endtask

    task automatic do_read(input int p, input logic [8:0] a, input logic [3:0] m, output int waited);
        bit got;
        exp_t e;
        got = 0;
        waited = 0;
        rd_valid[p] = 1'b1; rd_addr[p*9 +: 9] = a; rd_mask[p*4 +: 4] = m;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (rd_ready[p] === 1'b1) begin
                got = 1;
                break;
            end
            waited++;
            @(posedge clk); #1;
        end
        n_checks++;
        if (!got) begin
            n_fail++;
            $display("FAIL read_grant: port %0d rd_ready never set (got %b)", p, rd_ready);
        end else begin
            e.pid  = 2'(p);
            e.data = model_read(a, m);
            sb.push_back(e);
        end
        @(posedge clk); #1;
        rd_valid[p] = 1'b0;
    endtask

    task automatic test_reset();
        wr_valid[0] = 1'b1; wvalid[0] = 1'b1; rd_valid[2] = 1'b1;
        @(negedge clk);
        n_checks++;
        if (wr_ready !== 4'b0 || wready !== 4'b0 || rd_ready !== 4'b0) begin
            n_fail++;
            $display("FAIL reset_ready: wr_ready %b wready %b rd_ready %b want 0", wr_ready, wready, rd_ready);
        end
        n_checks++;
        if (rvalid !== 4'b0 || rdata !== 256'd0) begin
            n_fail++;
            $display("FAIL reset_read_out: rvalid %b rdata %h want 0", rvalid, rdata);
        end
        wr_valid[0] = 1'b0; wvalid[0] = 1'b0; rd_valid[2] = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_busy: got %b want 0", busy);
        end
        @(posedge clk); #1;
    endtask

    task automatic test_write_read();
        logic [3:0][63:0] d;
        int w;
        for (int b = 0; b < 4; b++) d[b] = 64'hA000_0000_0000_0000 + 64'(b);
        do_write(1, 9'h010, 4'hF, 1'b0, d, w);
        do_read(1, 9'h010, 4'hF, w);
        idle(2);
    endtask

    task automatic test_forward();
        logic [3:0][63:0] d1, d2;
        int w0, w1, w2;
        for (int b = 0; b < 4; b++) begin
            d1[b] = 64'(10 + b);
            d2[b] = 64'(20 + b);
        end
        do_write(2, 9'h030, 4'hF, 1'b0, d1, w0);
        do_write(2, 9'h030, 4'hF, 1'b1, d2, w1);
        do_read(2, 9'h030, 4'hF, w2);
        n_checks++;
        if (w1 != 0 || w2 != 0) begin
            n_fail++;
            $display("FAIL back_to_back: wait cycles got %0d,%0d want 0,0", w1, w2);
        end
        idle(2);
    endtask

    task automatic rr_pair(input logic [3:0] first, input logic [3:0] second, input logic [8:0] base);
        logic [3:0][63:0] d;
        int pf, ps;
        pf = (first == 4'b0001) ? 0 : 3;
        ps = (second == 4'b0001) ? 0 : 3;
        for (int b = 0; b < 4; b++) d[b] = 64'h5500 + 64'(b) + 64'(base);
        for (int p = 0; p < 4; p += 3) begin
            wr_valid[p] = 1'b1; wvalid[p] = 1'b1; accum_en[p] = 1'b0;
            wr_addr[p*9 +: 9] = base + 9'(p); wr_mask[p*4 +: 4] = 4'hF; wdata[p*256 +: 256] = d;
        end
        @(negedge clk);
        n_checks++;
        if (wr_ready !== first) begin
            n_fail++;
            $display("FAIL rr_first: wr_ready got %b want %b", wr_ready, first);
        end
        model_write(base + 9'(pf), 4'hF, 1'b0, d);
        @(posedge clk); #1;
        wr_valid[pf] = 1'b0; wvalid[pf] = 1'b0;
        @(negedge clk);
        n_checks++;
        if (wr_ready !== second) begin
            n_fail++;
            $display("FAIL rr_second: wr_ready got %b want %b", wr_ready, second);
        end
        model_write(base + 9'(ps), 4'hF, 1'b0, d);
        @(posedge clk); #1;
        wr_valid[ps] = 1'b0; wvalid[ps] = 1'b0;
    endtask

    task automatic test_round_robin();
        logic [3:0][63:0] d;
        int w;
        apply_reset();
        rr_pair(4'b0001, 4'b1000, 9'h100);
        for (int b = 0; b < 4; b++) d[b] = 64'h77 + 64'(b);
        do_write(1, 9'h101, 4'hF, 1'b0, d, w);
        rr_pair(4'b1000, 4'b0001, 9'h110);
        idle(2);
    endtask

    task automatic test_mask();
        logic [3:0][63:0] d;
        int w;
        for (int b = 0; b < 4; b++) d[b] = 64'(5 + b);
        do_write(0, 9'h040, 4'hF, 1'b0, d, w);
        d = '0;
        do_write(0, 9'h040, 4'b0101, 1'b0, d, w);
        do_read(0, 9'h040, 4'b0011, w);
        do_read(0, 9'h040, 4'hF, w);
        d = '1;
        do_write(0, 9'h040, 4'b0000, 1'b1, d, w);
        do_read(0, 9'h040, 4'hF, w);
        idle(2);
    endtask

    task automatic test_wrap();
        logic [3:0][63:0] d;
        int w;
        d[0] = '1; d[1] = 64'd1; d[2] = 64'd2; d[3] = 64'd3;
        do_write(3, 9'h050, 4'hF, 1'b0, d, w);
        idle(2);
        d = '0; d[0] = 64'd2; d[1] = 64'd4;
        do_write(3, 9'h050, 4'b0011, 1'b1, d, w);
        idle(2);
        do_read(3, 9'h050, 4'hF, w);
        idle(2);
    endtask

    task automatic test_reset_mid();
        logic [3:0][63:0] d;
        bit got;
        exp_t e;
        got = 0;
        rd_valid[0] = 1'b1; rd_addr[0 +: 9] = 9'h010; rd_mask[0 +: 4] = 4'hF;
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            if (rd_ready[0] === 1'b1) begin
                got = 1;
                break;
            end
            @(posedge clk); #1;
        end
        n_checks++;
        if (!got) begin
            n_fail++;
            $display("FAIL midreset_grant: rd_ready got %b want 0001", rd_ready);
        end
        @(posedge clk); #1;
        rst = 1'b1; rd_valid[0] = 1'b0;
        @(negedge clk);
        n_checks++;
        if (rvalid !== 4'b0 || busy !== 1'b0 || rdata !== 256'd0) begin
            n_fail++;
            $display("FAIL midreset_drop: rvalid %b busy %b rdata %h want 0", rvalid, busy, rdata);
        end
        @(posedge clk); #1;
        rst = 1'b0;
        for (int b = 0; b < 4; b++) d[b] = 64'hC0DE_0000 + 64'(b);
        wr_valid[2] = 1'b1; wvalid[2] = 1'b1; accum_en[2] = 1'b0;
        wr_addr[18 +: 9] = 9'h060; wr_mask[8 +: 4] = 4'hF; wdata[512 +: 256] = d;
        rd_valid[2] = 1'b1; rd_addr[18 +: 9] = 9'h060; rd_mask[8 +: 4] = 4'hF;
        @(negedge clk);
        n_checks++;
        if (wr_ready !== 4'b0100 || rd_ready !== 4'b0000) begin
            n_fail++;
            $display("FAIL post_reset_ptr: wr_ready %b rd_ready %b want 0100 0000", wr_ready, rd_ready);
        end
        model_write(9'h060, 4'hF, 1'b0, d);
        @(posedge clk); #1;
        wr_valid[2] = 1'b0; wvalid[2] = 1'b0;
        @(negedge clk);
        n_checks++;
        if (rd_ready !== 4'b0100) begin
            n_fail++;
            $display("FAIL post_reset_read: rd_ready got %b want 0100", rd_ready);
        end else begin
            e.pid  = 2'd2;
            e.data = model_read(9'h060, 4'hF);
            sb.push_back(e);
        end
        @(posedge clk); #1;
        rd_valid[2] = 1'b0;
        idle(4);
    endtask

    initial begin
        rst = 1'b1;
        wr_valid = '0; wvalid = '0; accum_en = '0; rd_valid = '0;
        wr_addr = '0; rd_addr = '0; wr_mask = '0; rd_mask = '0; wdata = '0;
        idle(3);
        test_reset();
        test_write_read();
        test_forward();
        test_round_robin();
        test_mask();
        test_wrap();
        test_reset_mid();
        n_checks++;
        if (sb.size() != 0) begin
            n_fail++;
            $display("FAIL scoreboard_drain: %0d reads outstanding, want 0", sb.size());
        end
        n_checks++;
        if (busy !== 1'b0) begin
            n_fail++;
            $display("FAIL idle_busy: got %b want 0", busy);
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
